// File: rtl/cu_id_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of {instr, pc}
// pairs with valid/ready on both sides, stall hold, flush, and occupancy reporting.
module cu_id_queue #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     soc_clk,
    input  logic                     IDQ_reset,
    input  logic                     fetch_valid,
    input  logic [XLEN-1:0]          fetch_instr,
    input  logic [PC_W-1:0]          fetch_pc,
    output logic                     fetch_ready,
    output logic                     decode_valid,
    output logic [XLEN-1:0]          decode_instr,
    output logic [PC_W-1:0]          decode_pc,
    input  logic                     decode_ready,
    input  logic                     ID_stall,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   max_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] max_count_q, max_count_d;
    logic          push, pop;

    // Full/empty come from the occupancy counter, so pointers may simply wrap.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fetch_ready  = (count_q != FULL_COUNT);
        decode_valid = (count_q != '0);
        push         = fetch_valid & fetch_ready & ~flush;
        pop          = decode_valid & decode_ready & ~ID_stall & ~flush;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
    end

    always_comb begin
        decode_instr = NOP_INSTR;
        decode_pc    = '0;
        if (decode_valid) begin
            decode_instr = mem_q[rd_ptr_q].instr;
            decode_pc    = mem_q[rd_ptr_q].pc;
        end
    end

    assign count     = count_q;
    assign max_count = max_count_q;

    always_ff @(posedge soc_clk or posedge IDQ_reset) begin
        if (IDQ_reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            max_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            max_count_q <= max_count_d;
        end
    end

    // NOTE: storage has no reset; a zero count already marks every slot as invalid.
    always_ff @(posedge soc_clk) begin
        if (push) mem_q[wr_ptr_q] <= '{instr: fetch_instr, pc: fetch_pc};
    end

endmodule

// File: tb/tb_cu_id_queue.sv
// Self-checking bench for cu_id_queue: directed test-plan steps plus random
// traffic, all compared against a queue-based reference model.
module tb_cu_id_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        soc_clk;
    logic        IDQ_reset;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        decode_valid;
    logic [31:0] decode_instr;
    logic [31:0] decode_pc;
    logic        decode_ready;
    logic        ID_stall;
    logic        flush;
    logic [2:0]  count;
    logic [2:0]  max_count;

    cu_id_queue #(.XLEN(32), .PC_W(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .soc_clk      (soc_clk),
        .IDQ_reset    (IDQ_reset),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .decode_valid (decode_valid),
        .decode_instr (decode_instr),
        .decode_pc    (decode_pc),
        .decode_ready (decode_ready),
        .ID_stall     (ID_stall),
        .flush        (flush),
        .count        (count),
        .max_count    (max_count)
    );

    initial begin
        soc_clk = 1'b0;
        forever #5 soc_clk = ~soc_clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];
    int   m_max;
    int   tests;
    int   fails;

    task automatic check(input string tag, input string what,
                         input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        e_instr = NOP;
        e_pc    = '0;
        if (mq.size() != 0) begin
            e_instr = mq[0].instr;
            e_pc    = mq[0].pc;
        end
        check(tag, "decode_valid", 64'(decode_valid), 64'(mq.size() != 0));
        check(tag, "decode_instr", 64'(decode_instr), 64'(e_instr));
        check(tag, "decode_pc",    64'(decode_pc),    64'(e_pc));
        check(tag, "fetch_ready",  64'(fetch_ready),  64'(mq.size() != DEPTH));
        check(tag, "count",        64'(count),        64'(mq.size()));
        check(tag, "max_count",    64'(max_count),    64'(m_max));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic cycle(input string tag, input logic fv, input logic [31:0] ins,
                         input logic [31:0] pc, input logic dr, input logic st,
                         input logic fl);
        bit do_pop;
        bit do_push;
        fetch_valid  = fv;
        fetch_instr  = ins;
        fetch_pc     = pc;
        decode_ready = dr;
        ID_stall     = st;
        flush        = fl;
        if (fl) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && dr && !st;
            do_push = fv && (mq.size() != DEPTH);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back('{instr: ins, pc: pc});
        end
        if (mq.size() > m_max) m_max = mq.size();
        @(posedge soc_clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        fetch_valid  = 1'b0;
        fetch_instr  = '0;
        fetch_pc     = '0;
        decode_ready = 1'b0;
        ID_stall     = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2;
        IDQ_reset = 1'b1;
        mq.delete();
        m_max = 0;
        #1;
        check_all("reset");
        #2;
        IDQ_reset = 1'b0;
        @(posedge soc_clk);
        #1;
        check_all("reset_rel");
    endtask

    logic [31:0] head_instr;
    logic [31:0] head_pc;

    initial begin
        tests = 0;
        fails = 0;
        m_max = 0;
        IDQ_reset = 1'b1;
        idle_inputs();
        #2;
        check_all("por");
        #10;
        IDQ_reset = 1'b0;
        @(posedge soc_clk);
        #1;
        check_all("por_rel");

        // Flush priority on a fresh queue: max_count must survive the flush.
        for (int i = 0; i < 3; i++)
            cycle("flush_fill", 1'b1, 32'hF000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0, 1'b0);
        check("flush_fill", "count", 64'(count), 64'd3);
        cycle("flush", 1'b1, 32'hDEAD_BEEF, 32'h100, 1'b1, 1'b1, 1'b1);
        check("flush", "count", 64'(count), 64'd0);
        check("flush", "max_count", 64'(max_count), 64'd3);
        check("flush", "fetch_ready", 64'(fetch_ready), 64'd1);

        // Fill then drain in order, ending on the NOP.
        for (int i = 0; i < 4; i++)
            cycle("fill", 1'b1, 32'hA000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0, 1'b0);
        check("fill", "fetch_ready", 64'(fetch_ready), 64'd0);
        check("fill", "count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain", "decode_instr", 64'(decode_instr), 64'(32'hA000_0000 + 32'(i)));
            cycle("drain", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        check("drain_empty", "decode_instr", 64'(decode_instr), 64'(32'h0000_0013));
        check("drain_empty", "decode_valid", 64'(decode_valid), 64'd0);

        // Continuous push/pop across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            cycle("wrap", 1'b1, 32'hB000_0000 + 32'(i), 32'(i * 4), 1'b1, 1'b0, 1'b0);
            check("wrap", "pc", 64'(decode_pc), 64'(i * 4));
        end
        cycle("wrap_end", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Stall hold with two entries.
        for (int i = 0; i < 2; i++)
            cycle("stall_fill", 1'b1, 32'hC000_0000 + 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        head_instr = decode_instr;
        head_pc    = decode_pc;
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
            check("stall", "held_instr", 64'(decode_instr), 64'(32'hC000_0000));
            check("stall", "held_pc", 64'(decode_pc), 64'(32'h200));
        end
        cycle("stall_rel", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("stall_rel", "next_pc", 64'(decode_pc), 64'(32'h204));
        cycle("stall_rel", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Full queue with a simultaneous pop.
        for (int i = 0; i < 4; i++)
            cycle("full_fill", 1'b1, 32'hD000_0000 + 32'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        cycle("full_pop", 1'b1, 32'hD000_0004, 32'h310, 1'b1, 1'b0, 1'b0);
        check("full_pop", "count", 64'(count), 64'd3);
        cycle("full_pop2", 1'b1, 32'hD000_0005, 32'h314, 1'b1, 1'b0, 1'b0);
        check("full_pop2", "count", 64'(count), 64'd3);
        check("full_pop2", "max_count", 64'(max_count), 64'd4);
        cycle("full_flush", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Async reset mid-stream; inputs during reset must be ignored.
        for (int i = 0; i < 2; i++)
            cycle("ar_fill", 1'b1, 32'hE000_0000 + 32'(i), 32'h400 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        #3;
        IDQ_reset = 1'b1;
        mq.delete();
        m_max = 0;
        #1;
        check_all("async_rst");
        check("async_rst", "count", 64'(count), 64'd0);
        fetch_valid = 1'b1;
        fetch_instr = 32'h1234_5678;
        fetch_pc    = 32'h500;
        @(posedge soc_clk);
        #1;
        check_all("rst_held");
        idle_inputs();
        #2;
        IDQ_reset = 1'b0;
        @(posedge soc_clk);
        #1;
        cycle("ar_push", 1'b1, 32'hE100_0000, 32'h600, 1'b0, 1'b0, 1'b0);
        check("ar_push", "pc", 64'(decode_pc), 64'(32'h600));

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle("rand", $urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
